// File: rtl/ntt_stage_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ntt_stage_ctrl
// Brief    : Sequencer for a D-lane iterative NTT butterfly datapath: load,
//            L butterfly stages, then hold the result until consumed.
// Revision : 1.0 - initial release
// ============================================================================
module ntt_stage_ctrl #(
  parameter  int N  = 17,
  parameter  int D  = 8,
  localparam int L  = $clog2(D),
  localparam int SW = ($clog2(L) < 1) ? 1 : $clog2(L)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            load,
  output logic            reg_en,
  output logic [SW-1:0]   stage,
  output logic [D-1:0]    sub,
  output logic [D*N-1:0]  psi_addr,
  output logic            busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_STAGE = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [SW-1:0] c_last_stage = SW'(L - 1);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [SW-1:0] r_stage;
  logic [SW-1:0] w_stage_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_stage <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_stage <= w_stage_nxt;
    end
  end

  // The stage counter only moves inside STAGE and is parked at 0 elsewhere.
  always_comb begin
    w_state_nxt = r_state;
    w_stage_nxt = r_stage;
    case (r_state)
      S_IDLE: begin
        if (in_valid) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_state_nxt = S_STAGE;
        w_stage_nxt = '0;
      end
      S_STAGE: begin
        if (r_stage == c_last_stage) begin
          w_state_nxt = S_OUT;
          w_stage_nxt = '0;
        end else begin
          w_stage_nxt = r_stage + SW'(1);
        end
      end
      S_OUT: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_stage_nxt = '0;
      end
    endcase
  end

  // Gated by rst so every handshake output is low while reset is held.
  always_comb begin
    in_ready  = 1'b0;
    load      = 1'b0;
    reg_en    = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE:  in_ready  = 1'b1;
        S_LOAD:  begin load   = 1'b1; busy = 1'b1; end
        S_STAGE: begin reg_en = 1'b1; busy = 1'b1; end
        S_OUT:   out_valid = 1'b1;
        default: in_ready  = 1'b0;
      endcase
    end
  end

  assign stage = r_stage;

  // Lane i at stage j: sub = bit (L-j-1) of i, twiddle = (i >> (L-j)) + 2^j.
  for (genvar i = 0; i < D; i++) begin : g_lane
    localparam logic [31:0] c_lane = 32'(i);
    logic          w_sub;
    logic [N-1:0]  w_psi;

    always_comb begin
      w_sub = 1'b0;
      w_psi = '0;
      for (int j = 0; j < L; j++) begin
        if (r_stage == SW'(j)) begin
          w_sub = c_lane[L-j-1];
          w_psi = N'(c_lane >> (L - j)) + (N'(1) << j);
        end
      end
    end

    assign sub[i]             = w_sub;
    assign psi_addr[N*i +: N] = w_psi;
  end

endmodule
`default_nettype wire
